if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
Instruction-fetch stage directly upstream of the instruction memory. It owns the PC register and drives the memory's 8-bit word-index address. It captures the combinational instruction returned in the same cycle into the IF/ID pipeline register. It handles stall, redirect (branch/jump flush) and halt.

Parameters:
PC_W, 8, width of the PC, which is a word index rather than a byte address
INSTR_W, 32, instruction width
MEM_DEPTH, 64, number of instruction words; valid indices are 0..MEM_DEPTH-1
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
imem_pc  out  PC_W  word index to instruction memory; always equals pc_q
imem_instruction  in  INSTR_W  combinational read data for imem_pc
stall  in  1  hold PC and IF/ID contents
redirect_valid  in  1  load a new PC and flush IF/ID
redirect_pc  in  PC_W  redirect target word index
halt_req  in  1  stop fetching (from decode: syscall/break)
ifid_valid  out  1  IF/ID holds a live instruction
ifid_instruction  out  INSTR_W  captured instruction; 0 (NOP) when invalid
ifid_pc  out  PC_W  index the instruction was fetched from
ifid_pc_plus1  out  PC_W  ifid_pc+1, modulo 2^PC_W
halted  out  1  high while the state is HALT

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled on the rising edge.
- Reset values:
  - pc_q=RESET_PC, state=IDLE
  - ifid_valid=0, ifid_instruction=0, ifid_pc=0, ifid_pc_plus1=0
  - halted=0
- Reset mid-operation overrides every other input.
- imem_pc is pc_q, combinational. Read data is captured on the same edge it is presented. Fetch latency is one cycle from pc_q to IF/ID.
- States: IDLE, RUN, HALT.
- IDLE (one cycle after reset):
  - ifid_valid stays 0 and pc_q holds; next state is RUN.
  - The first valid IF/ID appears after the 2nd rising edge following reset deassertion.
- Priority each edge: reset > redirect_valid > halt_req > stall > normal advance.
- redirect_valid, in any state including IDLE and HALT, regardless of stall:
  - If redirect_pc < MEM_DEPTH: pc_q<=redirect_pc, ifid_valid<=0, ifid_instruction<=0, state<=RUN.
  - If redirect_pc >= MEM_DEPTH: IF/ID is flushed the same way and state<=HALT.
- halt_req (no redirect): ifid_valid<=0, ifid_instruction<=0, state<=HALT, pc_q holds.
- stall in RUN (no redirect, no halt_req): pc_q and all IF/ID outputs hold their values.
- Normal advance in RUN:
  - ifid_valid<=1, ifid_instruction<=imem_instruction, ifid_pc<=pc_q, ifid_pc_plus1<=pc_q+1.
  - If pc_q==MEM_DEPTH-1: the last word is still captured, pc_q holds, and state<=HALT next edge. The PC never wraps to 0.
  - Otherwise pc_q<=pc_q+1.
- HALT:
  - ifid_valid<=0 on every edge and pc_q holds.
  - stall and halt_req are ignored. Only reset or redirect_valid exits.
- halted is registered and equals (state==HALT).
- Arithmetic: all PC arithmetic is unsigned PC_W-bit, truncated.

Optional Feature:
- Macro: IF_FETCH_PERF_CNT_EN.
- When defined, two extra output ports are added:
  - perf_fetch_cnt [15:0]: increments on every normal advance.
  - perf_stall_cnt [15:0]: increments on every edge where stall is honoured.
- Both counters saturate at 16'hFFFF and clear on reset.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package if_fetch_pkg holds:
  - the state enum {IDLE, RUN, HALT}
  - NOP_INSTR=32'h0000_0000
  - default PC_W, INSTR_W and MEM_DEPTH constants
- One natural sub-module: if_perf_counter, a saturating 16-bit counter with enable and synchronous clear. It is instantiated twice, only under IF_FETCH_PERF_CNT_EN.

Test Plan:
- Reset then run, memory word k = 32'h1000_0000+k → ifid_valid=0 for IDLE; then ifid_pc=0,1,2 with instruction 32'h1000_0000, 32'h1000_0001, 32'h1000_0002 and ifid_pc_plus1=1,2,3.
- stall held 3 cycles at pc_q=5 → imem_pc=5 and IF/ID frozen at pc 4 for 3 cycles. Next edge captures pc 5.
- redirect_valid=1, redirect_pc=8'h20, with stall=1 in the same cycle → next edge pc_q=32, ifid_valid=0. The following edge gives ifid_pc=32.
- Run to pc_q=63 → pc 63 captured with valid=1, then halted=1, ifid_valid=0 and imem_pc stays 63. A redirect to 2 resumes with halted=0.
- halt_req pulse at pc 10, followed by redirect_pc=8'h50 → first: HALT, IF/ID flushed. Then (80 >= 64): HALT, halted=1, ifid_valid=0.
- reset asserted mid-run at pc 17 → all outputs return to reset values on that edge. With IF_FETCH_PERF_CNT_EN, both counters read 0.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared types and default sizes for the instruction-fetch stage.
package if_fetch_pkg;

  localparam int unsigned PC_W_DEF      = 8;
  localparam int unsigned INSTR_W_DEF   = 32;
  localparam int unsigned MEM_DEPTH_DEF = 64;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } fetch_state_e;

endpackage

// File: rtl/if_perf_counter.sv
// Saturating 16-bit event counter with enable and synchronous clear.
module if_perf_counter (
  input  logic        clk,
  input  logic        clear,
  input  logic        en,
  output logic [15:0] count
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, stall/redirect/halt.
// Optional performance counters are built when IF_FETCH_PERF_CNT_EN is defined.
module if_fetch_stage
  import if_fetch_pkg::*;
#(
  parameter int unsigned PC_W      = PC_W_DEF,
  parameter int unsigned INSTR_W   = INSTR_W_DEF,
  parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    imem_pc,
  input  logic [INSTR_W-1:0] imem_instruction,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               halt_req,
  output logic               ifid_valid,
  output logic [INSTR_W-1:0] ifid_instruction,
  output logic [PC_W-1:0]    ifid_pc,
  output logic [PC_W-1:0]    ifid_pc_plus1,
  output logic               halted
`ifdef IF_FETCH_PERF_CNT_EN
  ,
  output logic [15:0]        perf_fetch_cnt,
  output logic [15:0]        perf_stall_cnt
`endif
);

  localparam logic [PC_W:0]      DEPTH_X = (PC_W + 1)'(MEM_DEPTH);
  localparam logic [PC_W-1:0]    LAST_PC = PC_W'(MEM_DEPTH - 1);
  localparam logic [PC_W-1:0]    RST_PC  = PC_W'(RESET_PC);
  localparam logic [INSTR_W-1:0] NOP     = INSTR_W'(NOP_INSTR);

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               ifid_valid_q, ifid_valid_d;
  logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
  logic [PC_W-1:0]    ifid_pc_q, ifid_pc_d;
  logic [PC_W-1:0]    ifid_pc_plus1_q, ifid_pc_plus1_d;
  logic               halted_q, halted_d;
  logic               redirect_in_range;

  assign redirect_in_range = ({1'b0, redirect_pc} < DEPTH_X);

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    ifid_valid_d    = ifid_valid_q;
    ifid_instr_d    = ifid_instr_q;
    ifid_pc_d       = ifid_pc_q;
    ifid_pc_plus1_d = ifid_pc_plus1_q;

    if (redirect_valid) begin
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP;
      if (redirect_in_range) begin
        pc_d    = redirect_pc;
        state_d = RUN;
      end else begin
        state_d = HALT;
      end
    end else if (state_q == HALT) begin
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP;
    end else if (halt_req) begin
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP;
      state_d      = HALT;
    end else if (state_q == IDLE) begin
      state_d = RUN;
    end else if (!stall) begin
      ifid_valid_d    = 1'b1;
      ifid_instr_d    = imem_instruction;
      ifid_pc_d       = pc_q;
      ifid_pc_plus1_d = pc_q + PC_W'(1);
      // The last word is fetched once; the PC parks there instead of wrapping.
      if (pc_q == LAST_PC) begin
        state_d = HALT;
      end else begin
        pc_d = pc_q + PC_W'(1);
      end
    end

    halted_d = (state_d == HALT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      pc_q            <= RST_PC;
      ifid_valid_q    <= 1'b0;
      ifid_instr_q    <= NOP;
      ifid_pc_q       <= '0;
      ifid_pc_plus1_q <= '0;
      halted_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      ifid_valid_q    <= ifid_valid_d;
      ifid_instr_q    <= ifid_instr_d;
      ifid_pc_q       <= ifid_pc_d;
      ifid_pc_plus1_q <= ifid_pc_plus1_d;
      halted_q        <= halted_d;
    end
  end

  assign imem_pc          = pc_q;
  assign ifid_valid       = ifid_valid_q;
  assign ifid_instruction = ifid_instr_q;
  assign ifid_pc          = ifid_pc_q;
  assign ifid_pc_plus1    = ifid_pc_plus1_q;
  assign halted           = halted_q;

`ifdef IF_FETCH_PERF_CNT_EN
  logic fetch_en;
  logic stall_en;

  // Same qualification as the advance/stall branches above, minus reset (clear wins).
  assign stall_en = (state_q == RUN) && !redirect_valid && !halt_req && stall;
  assign fetch_en = (state_q == RUN) && !redirect_valid && !halt_req && !stall;

  if_perf_counter u_fetch_cnt (
    .clk   (clk),
    .clear (reset),
    .en    (fetch_en),
    .count (perf_fetch_cnt)
  );

  if_perf_counter u_stall_cnt (
    .clk   (clk),
    .clear (reset),
    .en    (stall_en),
    .count (perf_stall_cnt)
  );
`else
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus randomized traffic
// against a behavioural fetch model.
module tb_if_fetch_stage;

  logic        clk;
  logic        reset;
  logic [7:0]  imem_pc;
  logic [31:0] imem_instruction;
  logic        stall;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        halt_req;
  logic        ifid_valid;
  logic [31:0] ifid_instruction;
  logic [7:0]  ifid_pc;
  logic [7:0]  ifid_pc_plus1;
  logic        halted;
`ifdef IF_FETCH_PERF_CNT_EN
  logic [15:0] perf_fetch_cnt;
  logic [15:0] perf_stall_cnt;
`endif

  logic [31:0] mem [256];

  int checks   = 0;
  int failures = 0;

  // Behavioural model: mode 0 = waiting one cycle after reset, 1 = fetching, 2 = stopped.
  int          m_pc;
  int          m_mode;
  bit          m_valid;
  logic [31:0] m_instr;
  int          m_ifpc;
  int          m_plus1;
  int          m_fcnt;
  int          m_scnt;

  if_fetch_stage #(
    .PC_W      (8),
    .INSTR_W   (32),
    .MEM_DEPTH (64),
    .RESET_PC  (0)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .imem_pc          (imem_pc),
    .imem_instruction (imem_instruction),
    .stall            (stall),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .halt_req         (halt_req),
    .ifid_valid       (ifid_valid),
    .ifid_instruction (ifid_instruction),
    .ifid_pc          (ifid_pc),
    .ifid_pc_plus1    (ifid_pc_plus1),
    .halted           (halted)
`ifdef IF_FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt   (perf_fetch_cnt),
    .perf_stall_cnt   (perf_stall_cnt)
`endif
  );

  assign imem_instruction = mem[imem_pc];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit s, input bit rv, input int rp, input bit h);
    if (r) begin
      m_pc = 0; m_mode = 0; m_valid = 0; m_instr = 32'h0;
      m_ifpc = 0; m_plus1 = 0; m_fcnt = 0; m_scnt = 0;
    end else if (rv) begin
      m_valid = 0;
      m_instr = 32'h0;
      if (rp < 64) begin
        m_pc   = rp;
        m_mode = 1;
      end else begin
        m_mode = 2;
      end
    end else if (m_mode == 2) begin
      m_valid = 0;
      m_instr = 32'h0;
    end else if (h) begin
      m_valid = 0;
      m_instr = 32'h0;
      m_mode  = 2;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (s) begin
      if (m_scnt < 65535) m_scnt++;
    end else begin
      m_valid = 1;
      m_instr = mem[m_pc];
      m_ifpc  = m_pc;
      m_plus1 = (m_pc + 1) % 256;
      if (m_fcnt < 65535) m_fcnt++;
      if (m_pc == 63) m_mode = 2;
      else m_pc = m_pc + 1;
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, land just after the falling edge.
  task automatic step(input bit r, input bit s, input bit rv, input int rp, input bit h);
    reset          = r;
    stall          = s;
    redirect_valid = rv;
    redirect_pc    = 8'(rp);
    halt_req       = h;
    @(posedge clk);
    model_edge(r, s, rv, rp, h);
    @(negedge clk);
    #1;
  endtask

  task automatic run_to(input int target);
    int n = 0;
    while (imem_pc !== 8'(target) && n < 100) begin
      step(0, 0, 0, 0, 0);
      n++;
    end
    chk("run_to_pc", 32'(imem_pc), 32'(target));
  endtask

  // Compare process: every falling edge, DUT against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("imem_pc", 32'(imem_pc), 32'(m_pc));
      chk("ifid_valid", 32'(ifid_valid), 32'(m_valid));
      chk("ifid_instruction", ifid_instruction, m_instr);
      chk("ifid_pc", 32'(ifid_pc), 32'(m_ifpc));
      chk("ifid_pc_plus1", 32'(ifid_pc_plus1), 32'(m_plus1));
      chk("halted", 32'(halted), 32'(m_mode == 2));
`ifdef IF_FETCH_PERF_CNT_EN
      chk("perf_fetch_cnt", 32'(perf_fetch_cnt), 32'(m_fcnt));
      chk("perf_stall_cnt", 32'(perf_stall_cnt), 32'(m_scnt));
`endif
    end
  end

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 32'h1000_0000 + 32'(k);
    m_pc = 0; m_mode = 0; m_valid = 0; m_instr = 32'h0;
    m_ifpc = 0; m_plus1 = 0; m_fcnt = 0; m_scnt = 0;

    // Reset, IDLE cycle, then the first three fetches.
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("rst_valid", 32'(ifid_valid), 32'd0);
    chk("rst_pc", 32'(imem_pc), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    step(0, 0, 0, 0, 0);
    chk("idle_valid", 32'(ifid_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 0);
      chk("first_valid", 32'(ifid_valid), 32'd1);
      chk("first_pc", 32'(ifid_pc), 32'(k));
      chk("first_instr", ifid_instruction, 32'h1000_0000 + 32'(k));
      chk("first_plus1", 32'(ifid_pc_plus1), 32'(k + 1));
    end

    // Stall three cycles with pc_q = 5.
    run_to(5);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0, 0, 0);
      chk("stall_imem_pc", 32'(imem_pc), 32'd5);
      chk("stall_ifid_pc", 32'(ifid_pc), 32'd4);
    end
    step(0, 0, 0, 0, 0);
    chk("after_stall_pc", 32'(ifid_pc), 32'd5);

    // Redirect beats a simultaneous stall.
    step(0, 1, 1, 8'h20, 0);
    chk("redir_imem_pc", 32'(imem_pc), 32'd32);
    chk("redir_flush", 32'(ifid_valid), 32'd0);
    step(0, 0, 0, 0, 0);
    chk("redir_ifid_pc", 32'(ifid_pc), 32'd32);

    // End of memory: fetch word 63 once, then park.
    run_to(63);
    step(0, 0, 0, 0, 0);
    chk("last_valid", 32'(ifid_valid), 32'd1);
    chk("last_pc", 32'(ifid_pc), 32'd63);
    chk("last_plus1", 32'(ifid_pc_plus1), 32'd64);
    step(0, 0, 0, 0, 0);
    chk("end_halted", 32'(halted), 32'd1);
    chk("end_valid", 32'(ifid_valid), 32'd0);
    chk("end_imem_pc", 32'(imem_pc), 32'd63);
    step(0, 0, 1, 2, 0);
    chk("resume_halted", 32'(halted), 32'd0);
    chk("resume_pc", 32'(imem_pc), 32'd2);

    // halt_req, then an out-of-range redirect keeps it halted.
    run_to(10);
    step(0, 0, 0, 0, 1);
    chk("hreq_halted", 32'(halted), 32'd1);
    chk("hreq_valid", 32'(ifid_valid), 32'd0);
    step(0, 0, 1, 8'h50, 0);
    chk("oor_halted", 32'(halted), 32'd1);
    chk("oor_valid", 32'(ifid_valid), 32'd0);
    chk("oor_imem_pc", 32'(imem_pc), 32'd10);

    // Mid-run reset at pc 17.
    step(0, 0, 1, 12, 0);
    run_to(17);
    step(1, 0, 0, 0, 0);
    chk("mid_rst_pc", 32'(imem_pc), 32'd0);
    chk("mid_rst_valid", 32'(ifid_valid), 32'd0);
    chk("mid_rst_ifid_pc", 32'(ifid_pc), 32'd0);
    chk("mid_rst_halted", 32'(halted), 32'd0);
`ifdef IF_FETCH_PERF_CNT_EN
    chk("mid_rst_fcnt", 32'(perf_fetch_cnt), 32'd0);
    chk("mid_rst_scnt", 32'(perf_stall_cnt), 32'd0);
`endif

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      bit r, s, rv, h;
      int rp;
      r  = ($urandom_range(0, 99) < 2);
      rv = ($urandom_range(0, 99) < 8);
      h  = ($urandom_range(0, 99) < 4);
      s  = ($urandom_range(0, 99) < 25) && (m_mode != 0);
      rp = $urandom_range(0, 79);
      step(r, s, rv, rp, h);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
